// File: rtl/pixel_scheduler.sv
// pixel_scheduler
//   Walks a H_RES x V_RES raster, issuing one pixel coordinate per unstalled
//   cycle into a fixed-latency tracer pipeline, and writes each returning hit
//   result to a linear frame buffer. A tag pipeline shadows the tracer so
//   every write carries the address of the pixel that produced it.
//
// Ports
//   sysclk       clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        request to render one frame (accepted on its rising edge in IDLE)
//   abort        synchronous cancel of the frame in progress
//   fb_ready     frame buffer can accept a write this cycle
//   hit_in       tracer result, PIPE_LAT unstalled cycles after issue
//   pixel_x/y    coordinate driven into the tracer
//   pipe_stall   freeze for every tracer stage (= ~fb_ready)
//   fb_we        frame buffer write strobe
//   fb_addr      linear address of the pixel being written
//   fb_data      hit value being written
//   busy         frame in progress (ISSUE or DRAIN)
//   done         one-cycle pulse at frame completion
//   frame_count  completed frames since reset, wrapping
module pixel_scheduler #(
    parameter int H_RES    = 800,
    parameter int V_RES    = 600,
    parameter int PIPE_LAT = 12
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        fb_ready,
    input  logic        hit_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pipe_stall,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic        fb_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [9:0] Y_MAX = 10'(V_RES - 1);
    localparam int         IFW   = $clog2(PIPE_LAT + 1) + 1;

    logic [1:0]     r_state;
    logic [9:0]     r_x;
    logic [9:0]     r_y;
    logic [18:0]    r_addr;
    logic [IFW-1:0] r_inflight;
    logic [15:0]    r_fcount;
    logic           r_start_q;
    logic           r_tag_v [PIPE_LAT];
    logic [18:0]    r_tag_a [PIPE_LAT];

    logic           w_start_edge;
    logic           w_issue;
    logic           w_we;
    logic           w_last;
    logic [IFW-1:0] w_inflight_nxt;

    // Rising-edge qualification so a start held across a whole frame
    // cannot relaunch a second frame once the FSM returns to IDLE.
    assign w_start_edge = start & ~r_start_q;
    assign w_issue      = (r_state == S_ISSUE) & fb_ready;
    assign w_we         = r_tag_v[PIPE_LAT-1] & fb_ready;
    assign w_last       = (r_x == X_MAX) && (r_y == Y_MAX);

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_issue && !w_we)
            w_inflight_nxt = r_inflight + IFW'(1);
        else if (!w_issue && w_we)
            w_inflight_nxt = r_inflight - IFW'(1);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= '0;
            r_inflight <= '0;
            r_fcount   <= '0;
            r_start_q  <= 1'b0;
        end else begin
            r_start_q <= start;
            if (abort) begin
                r_state    <= S_IDLE;
                r_x        <= '0;
                r_y        <= '0;
                r_addr     <= '0;
                r_inflight <= '0;
            end else begin
                r_inflight <= w_inflight_nxt;
                case (r_state)
                    S_IDLE: begin
                        if (w_start_edge) begin
                            r_state <= S_ISSUE;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_addr  <= '0;
                        end
                    end
                    S_ISSUE: begin
                        if (w_issue) begin
                            if (w_last) begin
                                // Coordinates hold on the final pixel.
                                r_state <= S_DRAIN;
                            end else begin
                                r_addr <= r_addr + 19'd1;
                                if (r_x == X_MAX) begin
                                    r_x <= '0;
                                    r_y <= r_y + 10'd1;
                                end else begin
                                    r_x <= r_x + 10'd1;
                                end
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Look at the next in-flight value so DONE follows
                        // the final write directly.
                        if (w_inflight_nxt == '0)
                            r_state <= S_DONE;
                    end
                    S_DONE: begin
                        r_state  <= S_IDLE;
                        r_fcount <= r_fcount + 16'd1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v[0] <= 1'b0;
            r_tag_a[0] <= '0;
        end else if (abort) begin
            r_tag_v[0] <= 1'b0;
        end else if (fb_ready) begin
            r_tag_v[0] <= w_issue;
            r_tag_a[0] <= r_addr;
        end
    end

    for (genvar g = 1; g < PIPE_LAT; g++) begin : g_tag
        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                r_tag_v[g] <= 1'b0;
                r_tag_a[g] <= '0;
            end else if (abort) begin
                r_tag_v[g] <= 1'b0;
            end else if (fb_ready) begin
                r_tag_v[g] <= r_tag_v[g-1];
                r_tag_a[g] <= r_tag_a[g-1];
            end
        end
    end

    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign pipe_stall  = ~fb_ready;
    assign fb_we       = w_we;
    assign fb_addr     = r_tag_a[PIPE_LAT-1];
    assign fb_data     = hit_in;
    assign busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign frame_count = r_fcount;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Scoreboard bench for pixel_scheduler with a 4x2 raster and 3-cycle tracer.
// Each frame's fb_ready pattern is chosen up front; the expected write
// cycles, addresses, data, done cycle and per-cycle busy/pixel values are
// derived from it and queued before the stimulus is driven.
module tb_pixel_scheduler;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int L    = 3;
    localparam int N    = H * V;
    localparam int FW   = 80;
    localparam int MAXC = 4000;

    logic        sysclk = 1'b0;
    logic        rst_n, start, abort, fb_ready, hit_in;
    logic [9:0]  pixel_x, pixel_y;
    logic        pipe_stall, fb_we, fb_data, busy, done;
    logic [18:0] fb_addr;
    logic [15:0] frame_count;

    pixel_scheduler #(.H_RES(H), .V_RES(V), .PIPE_LAT(L)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .start(start), .abort(abort),
        .fb_ready(fb_ready), .hit_in(hit_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pipe_stall(pipe_stall), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .busy(busy), .done(done), .frame_count(frame_count)
    );

    always #5 sysclk = ~sysclk;

    typedef struct { int c; int a; bit d; } wr_t;
    wr_t wq[$];
    int  dq[$];

    bit  exp_busy [MAXC];
    int  exp_pix  [MAXC];
    int  exp_fc   [MAXC];
    bit  hit_tbl  [N];
    int  cyc = 0;
    int  fc_model = 0;
    int  total = 0;
    int  bad = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Tracer stand-in: returns the hit value of the pixel being written.
    always_comb hit_in = hit_tbl[fb_addr[2:0]];

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", nm, cyc, act, req);
        end
    endtask

    // Monitor: compares everything the DUT presents against the queues.
    always @(negedge sysclk) begin
        int c;
        c = cyc;
        chk(pipe_stall == !fb_ready, "pipe_stall", pipe_stall, !fb_ready);
        if (c < MAXC) begin
            chk(busy == exp_busy[c], "busy", busy, exp_busy[c]);
            if (exp_pix[c] >= 0) begin
                chk(pixel_x == 10'(exp_pix[c] % H), "pixel_x", pixel_x, exp_pix[c] % H);
                chk(pixel_y == 10'(exp_pix[c] / H), "pixel_y", pixel_y, exp_pix[c] / H);
            end
            if (exp_fc[c] >= 0)
                chk(frame_count == 16'(exp_fc[c]), "frame_count_busy", frame_count, exp_fc[c]);
        end
        if (wq.size() > 0 && wq[0].c == c) begin
            chk(fb_we, "fb_we_expected", fb_we, 1);
            chk(fb_addr == 19'(wq[0].a), "fb_addr", fb_addr, wq[0].a);
            chk(fb_data == wq[0].d, "fb_data", fb_data, wq[0].d);
            void'(wq.pop_front());
        end else begin
            chk(!fb_we, "fb_we_unexpected", fb_we, 0);
        end
        if (dq.size() > 0 && dq[0] == c) begin
            chk(done, "done_expected", done, 1);
            void'(dq.pop_front());
        end else begin
            chk(!done, "done_unexpected", done, 0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk(pixel_x == 10'd0, {tag, "_pixel_x"}, pixel_x, 0);
        chk(pixel_y == 10'd0, {tag, "_pixel_y"}, pixel_y, 0);
        chk(fb_we == 1'b0, {tag, "_fb_we"}, fb_we, 0);
        chk(fb_addr == 19'd0, {tag, "_fb_addr"}, fb_addr, 0);
        chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
        chk(done == 1'b0, {tag, "_done"}, done, 0);
        chk(frame_count == 16'd0, {tag, "_frame_count"}, frame_count, 0);
    endtask

    // One frame attempt. hold: cycles start stays high; st_at/st_len: forced
    // fb_ready=0 window (relative to the start cycle); rnd: random fb_ready in
    // the early part; abort_k: abort in the cycle pixel abort_k issues (-1 none);
    // rst_i: relative cycle in which rst_n is pulled low (-1 none).
    task automatic frame(input int hold, input int st_at, input int st_len,
                         input bit rnd, input int abort_k, input int rst_i);
        bit rdy [FW];
        int rl[$];
        int s, p, endc, a_i;
        bit full;
        s = cyc;
        for (int i = 0; i < FW; i++) begin
            rdy[i] = 1'b1;
            if (rnd && i < 40) rdy[i] = ($urandom_range(0, 3) != 0);
            if (i >= st_at && i < st_at + st_len) rdy[i] = 1'b0;
            if (i >= 1 && rdy[i]) rl.push_back(i);
        end
        // Pixel k issues on ready cycle rl[k]; its write lands L ready cycles later.
        full = (abort_k < 0);
        a_i  = full ? 0 : rl[abort_k];
        endc = full ? rl[N-1+L] + 1 : a_i + 1;
        p = 0;
        for (int i = 1; i < endc; i++) begin
            exp_busy[s+i] = 1'b1;
            exp_pix[s+i]  = (p < N - 1) ? p : N - 1;
            exp_fc[s+i]   = fc_model;
            if (rdy[i]) p++;
        end
        if (!full) exp_pix[s+endc] = 0;
        for (int k = 0; k < N; k++)
            if (full || rl[k+L] <= a_i)
                wq.push_back('{s + rl[k+L], k, hit_tbl[k]});
        if (full) dq.push_back(s + endc);

        for (int i = 0; i < FW; i++) begin
            start    = (i < hold);
            abort    = !full && (i == a_i) && (abort_k >= 0);
            fb_ready = rdy[i];
            if (i == rst_i) begin
                while (wq.size() > 0 && wq[$].c >= s + i) void'(wq.pop_back());
                dq.delete();
                for (int j = i; j < FW; j++) begin
                    exp_busy[s+j] = 1'b0;
                    exp_pix[s+j]  = -1;
                    exp_fc[s+j]   = -1;
                end
                exp_pix[s+i] = 0;
                full = 1'b0;
                fc_model = 0;
                #1 rst_n = 1'b0;
                #1 check_reset_outputs("mid_frame_reset");
            end
            if (rst_i >= 0 && i == rst_i + 2) rst_n = 1'b1;
            @(posedge sysclk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        fb_ready = 1'b1;
        if (full) fc_model++;
        chk(frame_count == 16'(fc_model), "frame_count_after", frame_count, fc_model);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_busy[i] = 1'b0;
            exp_pix[i]  = -1;
            exp_fc[i]   = -1;
        end
        for (int k = 0; k < N; k++) hit_tbl[k] = k[0];
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fb_ready = 1'b1;
        #2 check_reset_outputs("power_on_reset");
        repeat (3) @(posedge sysclk);
        #1 rst_n = 1'b1;
        @(posedge sysclk);
        #1;

        // Plain frame, hit = addr[0].
        frame(1, -1, 0, 1'b0, -1, -1);
        // Five stall cycles starting at the third issue.
        frame(1, 3, 5, 1'b0, -1, -1);
        // Abort as the fifth pixel issues, then a clean frame.
        frame(1, -1, 0, 1'b0, 4, -1);
        frame(1, -1, 0, 1'b0, -1, -1);
        // Start held high for 20 cycles: one frame only.
        frame(20, -1, 0, 1'b0, -1, -1);
        // Random back-pressure and hit data, one random abort.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++) hit_tbl[k] = 1'($urandom_range(0, 1));
            frame(1, -1, 0, 1'b1, (f == 3) ? int'($urandom_range(0, N - 1)) : -1, -1);
        end
        // Reset pulled low during DRAIN, then a fresh frame counting from zero.
        frame(1, -1, 0, 1'b0, -1, N + 2);
        frame(1, -1, 0, 1'b1, -1, -1);

        chk(wq.size() == 0, "writes_outstanding", wq.size(), 0);
        chk(dq.size() == 0, "done_outstanding", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
